// File: rtl/ntt_coeff_stream_if.sv
// ============================================================================
// Module : ntt_coeff_stream_if
// Brief  : Handshake and PU-side bundle for ntt_coeff_stream.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ntt_coeff_stream_if #(
  parameter int N = 17,
  parameter int D = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_data;
  logic           in_inv;
  logic [D*N-1:0] pu_a;
  logic           pu_inv;
  logic [D*N-1:0] pu_an;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_data;
  logic           busy;

  // Environment side: produces coefficients, the PU result and downstream ready.
  modport master (
    output in_valid, in_data, in_inv, pu_an, out_ready,
    input  in_ready, pu_a, pu_inv, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_inv, pu_an, out_ready,
    output in_ready, pu_a, pu_inv, out_valid, out_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/ntt_coeff_stream.sv
// ============================================================================
// Module : ntt_coeff_stream
// Brief  : Serial-to-parallel loader, fixed-latency PU hold, parallel-to-serial
//          drain around the NTT/INTT processing unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ntt_coeff_stream #(
  parameter int N   = 17,
  parameter int D   = 16,
  parameter int LAT = 8
) (
  input  logic                clk,
  input  logic                rst,
  ntt_coeff_stream_if.slave   bus
);

  localparam int IDX_W  = (D   > 1) ? $clog2(D)   : 1;
  localparam int WCNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(D - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(LAT - 1);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]            state_q,    state_d;
  logic [IDX_W-1:0]      idx_q,      idx_d;
  logic [WCNT_W-1:0]     wcnt_q,     wcnt_d;
  logic [D-1:0][N-1:0]   load_buf_q, load_buf_d;
  logic [D-1:0][N-1:0]   res_q,      res_d;
  logic [D*N-1:0]        pu_a_q,     pu_a_d;
  logic                  pu_inv_q,   pu_inv_d;
  logic                  inv_q,      inv_d;

  // Handshake outputs depend only on registered state, never on valid/ready inputs.
  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.out_valid = (state_q == ST_DRAIN);
  assign bus.busy      = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  assign bus.out_data  = (state_q == ST_DRAIN) ? res_q[idx_q] : '0;
  assign bus.pu_a      = pu_a_q;
  assign bus.pu_inv    = pu_inv_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wcnt_d     = wcnt_q;
    load_buf_d = load_buf_q;
    res_d      = res_q;
    pu_a_d     = pu_a_q;
    pu_inv_d   = pu_inv_q;
    inv_d      = inv_q;

    case (state_q)
      ST_LOAD: begin
        if (bus.in_valid) begin
          load_buf_d[idx_q] = bus.in_data;
          if (idx_q == '0) begin
            inv_d = bus.in_inv;
          end
          if (idx_q == IDX_LAST) begin
            // Publish the buffer including the coefficient arriving on this edge.
            pu_a_d   = load_buf_d;
            pu_inv_d = inv_q;
            idx_d    = '0;
            wcnt_d   = '0;
            state_d  = ST_WAIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_WAIT: begin
        if (wcnt_q == WCNT_LAST) begin
          res_d   = bus.pu_an;
          wcnt_d  = '0;
          state_d = ST_DRAIN;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end

      ST_DRAIN: begin
        if (bus.out_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = ST_LOAD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      default: begin
        idx_d   = '0;
        wcnt_d  = '0;
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      wcnt_q     <= '0;
      load_buf_q <= '0;
      res_q      <= '0;
      pu_a_q     <= '0;
      pu_inv_q   <= 1'b0;
      inv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wcnt_q     <= wcnt_d;
      load_buf_q <= load_buf_d;
      res_q      <= res_d;
      pu_a_q     <= pu_a_d;
      pu_inv_q   <= pu_inv_d;
      inv_q      <= inv_d;
    end
  end

endmodule

`default_nettype wire
